// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer family: mode encodings,
// output-stage states and the channel-index width helper.
package mux_pkg;

    localparam bit MODE_FIXED = 1'b0;
    localparam bit MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant search: picks the first requesting channel at or after
// ptr, wrapping modulo N_CH, using a doubled request vector.
module rr_grant
    import mux_pkg::*;
#(
    parameter int  N_CH = 4,
    localparam int CW   = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [CW-1:0]   gnt_idx,
    output logic            gnt_valid
);

    logic [2*N_CH-1:0] req2;

    assign req2 = {req, req};

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // Walk downwards so the lowest position inside the window wins.
        for (int j = 2*N_CH-1; j >= 0; j--) begin
            if (req2[j] && (j >= int'(ptr)) && (j < int'(ptr) + N_CH)) begin
                gnt_valid = 1'b1;
                gnt_idx   = CW'(j % N_CH);
            end
        end
    end

endmodule

// File: rtl/mux_stream_arb.sv
// N-channel registered stream multiplexer: round-robin or fixed-select grant
// feeding a single back-pressured output register tagged with its channel.
module mux_stream_arb
    import mux_pkg::ch_idx_w;
    import mux_pkg::stage_e;
    import mux_pkg::ST_EMPTY;
    import mux_pkg::ST_FULL;
#(
    parameter int  N_CH    = 4,
    parameter int  W       = 8,
    parameter bit  MODE_RR = 1'b1,
    localparam int CW      = ch_idx_w(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic [CW-1:0]     sel,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam bit RR_EN = (MODE_RR != mux_pkg::MODE_FIXED);

    stage_e        state;
    stage_e        state_next;
    logic [CW-1:0] ptr;
    logic [CW-1:0] rr_idx;
    logic [CW-1:0] gnt_idx;
    logic          rr_valid;
    logic          fix_valid;
    logic          gnt_valid;
    logic          load_ok;
    logic          take;
    logic [W-1:0]  gnt_data;

    rr_grant #(.N_CH(N_CH)) u_rr_grant (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    // A sel value at or beyond N_CH matches no channel and therefore never grants.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if ((sel == CW'(i)) && in_valid[i]) fix_valid = 1'b1;
        end
    end

    assign gnt_idx   = RR_EN ? rr_idx   : sel;
    assign gnt_valid = RR_EN ? rr_valid : fix_valid;
    assign load_ok   = (state == ST_EMPTY) || out_ready;
    assign take      = gnt_valid && load_ok;
    assign out_valid = (state == ST_FULL);

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == CW'(i)) begin
                gnt_data    = in_data[i*W +: W];
                in_ready[i] = take;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_next;
    end

    // A load while FULL replaces the word in place, so the stage never bubbles.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: if (take) state_next = ST_FULL;
            ST_FULL:  if (out_ready && !take) state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else if (take) begin
            out_data <= gnt_data;
            out_ch   <= gnt_idx;
            if (RR_EN) ptr <= (gnt_idx == CW'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_stream_arb.sv
// Scoreboard bench for mux_stream_arb: RR and fixed 4-channel instances plus a
// 3-channel 16-bit RR instance under random back-pressure.
module tb_mux_stream_arb;

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: round-robin, 4 x 8 bit
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel, a_out_ch;
    logic [7:0]  a_out_data;
    logic        a_out_valid, a_out_ready;

    // Instance B: fixed select, 4 x 8 bit
    logic [31:0] b_in_data;
    logic [3:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_out_ch;
    logic [7:0]  b_out_data;
    logic        b_out_valid, b_out_ready;

    // Instance C: round-robin, 3 x 16 bit
    logic [47:0] c_in_data;
    logic [2:0]  c_in_valid, c_in_ready;
    logic [1:0]  c_sel, c_out_ch;
    logic [15:0] c_out_data;
    logic        c_out_valid, c_out_ready;

    mux_stream_arb #(.N_CH(4), .W(8), .MODE_RR(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_ch(a_out_ch),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    mux_stream_arb #(.N_CH(4), .W(8), .MODE_RR(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data), .out_ch(b_out_ch),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    mux_stream_arb #(.N_CH(3), .W(16), .MODE_RR(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data), .out_ch(c_out_ch),
        .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    task automatic pop_check_a(input string name);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got ch=%0d data=%h", name, a_out_ch, a_out_data);
        end else begin
            e = exp_q.pop_front();
            if (a_out_valid !== 1'b1 || a_out_ch !== e.ch[1:0] || a_out_data !== e.data[7:0]) begin
                n_fail++;
                $display("FAIL %s: got valid=%b ch=%0d data=%h, expected valid=1 ch=%0d data=%h",
                         name, a_out_valid, a_out_ch, a_out_data, e.ch, e.data[7:0]);
            end
        end
    endtask

    task automatic test_reset();
        a_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        a_in_valid = 4'hF;
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_a: got valid=%b data=%h ch=%0d, expected 0/00/0",
                     a_out_valid, a_out_data, a_out_ch);
        end
        n_checks++;
        if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0 || c_out_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bc: got b_valid=%b c_valid=%b c_data=%h, expected 0/0/0000",
                     b_out_valid, c_out_valid, c_out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_rr_all_valid();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            e.ch   = 4'(k % 4);
            e.data = 16'(8'hA0 + (k % 4));
            exp_q.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            pop_check_a($sformatf("rr_all_word%0d", k));
        end
    endtask

    task automatic test_rr_two_channels();
        exp_t e;
        a_in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            e.ch   = (k % 2 == 0) ? 4'd1 : 4'd3;
            e.data = (k % 2 == 0) ? 16'h00A1 : 16'h00A3;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ((a_in_ready & 4'b0101) !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_two_idle_ready%0d: got in_ready=%b, expected bits 0 and 2 low", k, a_in_ready);
            end
            @(posedge clk); #1;
            pop_check_a($sformatf("rr_two_word%0d", k));
        end
    endtask

    task automatic test_stall();
        exp_t e;
        a_in_valid = 4'hF;
        e.ch = 4'd0; e.data = 16'h00A0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        pop_check_a("stall_first_load");
        a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 4'($urandom_range(1, 15));
            @(negedge clk);
            n_checks++;
            if (a_in_ready !== 4'b0000 || a_out_valid !== 1'b1 || a_out_ch !== 2'd0 || a_out_data !== 8'hA0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got in_ready=%b valid=%b ch=%0d data=%h, expected 0000/1/0/a0",
                         k, a_in_ready, a_out_valid, a_out_ch, a_out_data);
            end
            @(posedge clk); #1;
        end
        a_in_valid = 4'hF;
        a_out_ready = 1'b1;
        e.ch = 4'd1; e.data = 16'h00A1; exp_q.push_back(e);
        e.ch = 4'd2; e.data = 16'h00A2; exp_q.push_back(e);
        @(posedge clk); #1;
        pop_check_a("stall_resume0");
        @(posedge clk); #1;
        pop_check_a("stall_resume1");
    endtask

    task automatic test_fixed_select();
        b_in_data = {8'h3D, 8'h5C, 8'h1B, 8'h0A};
        b_sel = 2'd2;
        b_in_valid = 4'b0100;
        b_out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL fixed_ready_sel2: got in_ready=%b, expected 0100", b_in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'h5C || b_out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL fixed_load_sel2: got valid=%b data=%h ch=%0d, expected 1/5c/2",
                     b_out_valid, b_out_data, b_out_ch);
        end
        b_sel = 2'd1;
        @(negedge clk);
        n_checks++;
        if (b_in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL fixed_ready_sel1_idle: got in_ready=%b, expected 0000", b_in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'h5C) begin
            n_fail++;
            $display("FAIL fixed_hold: got valid=%b data=%h, expected 1/5c", b_out_valid, b_out_data);
        end
        b_out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b_in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL fixed_ready_no_grant: got in_ready=%b, expected 0000", b_in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'h5C || b_out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL fixed_drain: got valid=%b data=%h ch=%0d, expected 0/5c/2",
                     b_out_valid, b_out_data, b_out_ch);
        end
        b_in_valid = 4'hF;
        @(negedge clk);
        n_checks++;
        if (b_in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL fixed_ready_sel1_all: got in_ready=%b, expected 0010", b_in_ready);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (b_out_valid !== 1'b1 || b_out_data !== 8'h1B || b_out_ch !== 2'd1) begin
                n_fail++;
                $display("FAIL fixed_no_rotate%0d: got valid=%b data=%h ch=%0d, expected 1/1b/1",
                         k, b_out_valid, b_out_data, b_out_ch);
            end
        end
        b_out_ready = 1'b0;
        b_in_valid = 4'b0000;
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_ch !== 2'd0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got a_valid=%b a_data=%h a_ch=%0d b_valid=%b, expected 0/00/0/0",
                     a_out_valid, a_out_data, a_out_ch, b_out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_ch !== 2'd0 || a_out_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL async_reset_ptr: got valid=%b ch=%0d data=%h, expected 1/0/a0",
                     a_out_valid, a_out_ch, a_out_data);
        end
    endtask

    task automatic test_n3_scoreboard();
        int   m = 24;
        int   cnt [3] = '{0, 0, 0};
        int   popped = 0;
        int   cyc = 0;
        logic [2:0] hs;
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < m; k++) begin
            e.ch   = 4'(k % 3);
            e.data = 16'(((k % 3) << 12) | (k / 3));
            exp_q.push_back(e);
        end
        c_in_valid = 3'b111;
        while (popped < m && cyc < 400) begin
            for (int i = 0; i < 3; i++) c_in_data[i*16 +: 16] = 16'((i << 12) | cnt[i]);
            c_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = c_in_valid & c_in_ready;
            n_checks++;
            if ($countones(c_in_ready) > 1) begin
                n_fail++;
                $display("FAIL n3_onehot cycle %0d: got in_ready=%b, expected at most one bit", cyc, c_in_ready);
            end
            if (c_out_valid === 1'b1 && c_out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL n3_extra_word: got ch=%0d data=%h, expected no more words", c_out_ch, c_out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (c_out_ch !== e.ch[1:0] || c_out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL n3_word%0d: got ch=%0d data=%h, expected ch=%0d data=%h",
                                 popped, c_out_ch, c_out_data, e.ch, e.data);
                    end
                end
                popped++;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (hs[i]) cnt[i]++;
            cyc++;
        end
        n_checks++;
        if (popped < m) begin
            n_fail++;
            $display("FAIL n3_timeout: got %0d words, expected %0d", popped, m);
        end
        c_in_valid = 3'b000;
    endtask

    initial begin
        rst = 1'b1;
        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
        c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;
        test_reset();
        test_rr_all_valid();
        test_rr_two_channels();
        test_stall();
        test_fixed_select();
        test_async_reset();
        test_n3_scoreboard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_stream_arb.md
# mux_stream_arb

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshake, the next generation of the team's 4:1 combinational data mux. Each cycle it selects one requesting input channel, either by an external select (fixed mode) or by a round-robin arbiter. It registers the chosen word together with its channel index into a single output stage that honours downstream back-pressure. It sits between multiple producers and a single shared consumer, such as a bus or UART TX path.

## Interface
- N_CH, 4: number of input channels; legal range 2..16; non-powers of two allowed.
- W, 8: data width per channel, ≥1.
- MODE_RR, 1: 1 = round-robin arbitration; 0 = fixed select via `sel`.
- CW, $clog2(N_CH): derived channel-index width; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N_CH*W  channel i occupies bits [i*W +: W].
- in_valid  in  N_CH  per-channel word-available flag.
- in_ready  out  N_CH  per-channel accept; combinational.
- sel  in  CW  channel select, used only when MODE_RR=0.
- out_data  out  W  registered selected word.
- out_ch  out  CW  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts a word.

## Operation
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_ok = ~out_valid | out_ready.
- Grant, RR mode: first index g with in_valid[g]=1, searching ptr, ptr+1, … with wrap mod N_CH.
- Grant, fixed mode: g = sel if in_valid[sel]=1; otherwise no grant. `sel` ≥ N_CH means no grant.
- At most one in_ready bit is high at any time: in_ready[g] = grant_valid & load_ok.
- Transfer-in on channel g (in_valid[g] & in_ready[g]) loads out_data=in_data[g], out_ch=g, out_valid=1.
- RR pointer updates to (g+1) mod N_CH only on a transfer-in. It is unchanged in fixed mode.
- Transfer-out (out_valid & out_ready) without a simultaneous transfer-in sets out_valid=0. out_data and out_ch hold their last values.
- Simultaneous transfer-out and transfer-in: the new word replaces the old one in the same edge, out_valid stays 1, and there is no bubble.
- FULL with out_ready=0: all in_ready=0. out_data, out_ch, out_valid and the pointer hold. Changes on `sel` or in_valid do not disturb the held word.
- in_valid dropping without a handshake is the producer's error. The block just re-arbitrates the next cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is therefore 0 until some in_valid is seen.
- Reset mid-operation discards any held word immediately (asynchronous). It does not wait for a clock edge.
- Latency is 1 cycle: a transfer-in at edge t gives out_valid=1 after edge t.
- Throughput is 1 word/cycle while out_ready=1.
- Combinational paths: in_valid/sel/out_ready → in_ready. There is no path from inputs to out_* (fully registered).
- Fairness in RR mode: with all N_CH channels continuously valid and out_ready=1, grants cycle 0,1,…,N_CH-1,0. Each channel waits at most N_CH-1 accepted words.

## Structure
- Shared package `mux_pkg`: the MODE_RR encodings (MODE_FIXED=0, MODE_RR=1) and a `ch_idx_w(n)` function returning max(1,$clog2(n)).
- One sub-module `rr_grant`: combinational, parameter N_CH.
  - Inputs: req[N_CH], ptr[CW].
  - Outputs: gnt_idx[CW], gnt_valid.
  - Implemented as a doubled-vector priority search.
- The top level holds the output register, the pointer register, the fixed-mode select logic, and the in_ready generation.

## Test plan
- Reset with all in_valid=1, then release, RR mode, N_CH=4, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles. out_data matches the per-channel patterns 8'hA0..8'hA3.
- Only channels 1 and 3 valid, RR → out_ch alternates 1,3,1,3. in_ready[0] and in_ready[2] are never high.
- out_ready=0 for 5 cycles after the first load → out_valid=1 and out_data/out_ch are stable, all in_ready=0, and ptr is unchanged. Raising out_ready resumes with the next RR channel.
- Fixed mode, sel=2, in_data[2]=8'h5C, in_valid=4'b0100 → out_data=8'h5C, out_ch=2 one cycle later. Then sel=1 with in_valid[1]=0 → in_ready=0 and out_valid falls after the pending word is consumed.
- Assert rst while out_valid=1 → out_valid, out_data and out_ch are 0 before the next clock edge.
- N_CH=3, W=16, all channels valid → out_ch wraps 0,1,2,0. Random out_ready stalls (50%) lose and duplicate no words, checked by a scoreboard.
